// File: rtl/serial_ripple_subtractor_if.sv
// ============================================================================
// Module   : serial_ripple_subtractor_if
// Brief    : Start/busy/done handshake and operand/result bus for the
//            bit-serial subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_ripple_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    // Requester side: issues operands, observes status and result.
    modport master (
        output start, A, B,
        input  busy, done, diff, borrow_out, overflow
    );

    // Subtractor side.
    modport slave (
        input  start, A, B,
        output busy, done, diff, borrow_out, overflow
    );
endinterface

`default_nettype wire

// File: rtl/serial_ripple_subtractor.sv
// ============================================================================
// Module   : serial_ripple_subtractor
// Brief    : Bit-serial DIFF = A - B, LSB-first, one full-subtractor cell and
//            a registered borrow; WIDTH cycles per operation.
//            Optional macro SERIAL_SUB_SIGNED_OVF_EN enables the signed
//            overflow flag (otherwise overflow is tied to 0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_ripple_subtractor #(
    parameter int WIDTH = 8
) (
    input  wire                            clk,
    input  wire                            rst_n,
    serial_ripple_subtractor_if.slave      bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;
    logic             w_accept;

    // Single full-subtractor cell operating on the current LSBs.
    assign w_a_bit    = r_a[0];
    assign w_b_bit    = r_b[0];
    assign w_d        = w_a_bit ^ w_b_bit ^ r_br;
    assign w_br_next  = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_br);
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};
    assign w_last     = (r_cnt == C_LAST_BIT);

    // Start is honoured in IDLE and, for back-to-back operation, in DONE.
    assign w_accept   = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic r_sign_a;
    logic r_sign_b;
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sign_a <= bus.A[WIDTH-1];
                r_sign_b <= bus.B[WIDTH-1];
            end
            // w_d at the last step is the result MSB.
            if ((r_state == S_RUN) && w_last) begin
                r_ovf <= (r_sign_a != r_sign_b) && (w_d != r_sign_a);
            end
        end
    end

    assign bus.overflow = r_ovf;
`else
    assign bus.overflow = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_a     <= bus.A;
                        r_b     <= bus.B;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                S_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_res_next;
                    r_br  <= w_br_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_diff   <= w_res_next;
                        r_borrow <= w_br_next;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow;

endmodule

`default_nettype wire

// File: tb/tb_serial_ripple_subtractor.sv
// ============================================================================
// Module   : tb_serial_ripple_subtractor
// Brief    : Self-checking bench for serial_ripple_subtractor (WIDTH=8),
//            directed cases followed by randomized operations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_ripple_subtractor;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    serial_ripple_subtractor_if #(.WIDTH(W)) bus ();

    serial_ripple_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        int r;
        r = int'(a) - int'(b);
        if (r < 0) r += (1 << W);
        return W'(r);
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        int sa, sb, sd;
        sa = (a >= (1 << (W-1))) ? int'(a) - (1 << W) : int'(a);
        sb = (b >= (1 << (W-1))) ? int'(b) - (1 << W) : int'(b);
        sd = sa - sb;
        return (sd > (1 << (W-1)) - 1) || (sd < -(1 << (W-1)));
`else
        return 1'b0;
`endif
    endfunction

    // Entered at a negedge; returns at the negedge of the DONE cycle when
    // chain is set (caller then issues the next start), else one cycle later.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit disturb, input bit chain);
        logic [W-1:0] ed;
        ed = ref_diff(a, b);
        bus.start = 1'b1;
        bus.A = a;
        bus.B = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A = W'($urandom);
        bus.B = W'($urandom);
        for (int i = 0; i < W; i++) begin
            chk("busy_run", bus.busy, 1);
            chk("done_run", bus.done, 0);
            bus.start = (disturb && i == 3) ? 1'b1 : 1'b0;
            if (disturb) begin
                bus.A = W'($urandom);
                bus.B = W'($urandom);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("done_pulse", bus.done, 1);
        chk("busy_done", bus.busy, 0);
        chk("diff", bus.diff, ed);
        chk("borrow", bus.borrow_out, (a < b) ? 1 : 0);
        chk("overflow", bus.overflow, ref_ovf(a, b));
        if (!chain) begin
            @(negedge clk);
            chk("done_single", bus.done, 0);
            chk("busy_idle", bus.busy, 0);
            chk("diff_hold", bus.diff, ed);
        end
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_diff", bus.diff, 0);
        chk("rst_borrow", bus.borrow_out, 0);
        chk("rst_ovf", bus.overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8'd48, 8'd15, 0, 0);
        do_op(8'd0, 8'd1, 0, 0);
        do_op(8'd248, 8'd3, 0, 0);
        do_op(8'd170, 8'd170, 0, 0);
        do_op(8'h80, 8'h01, 0, 0);
        do_op(8'h05, 8'h03, 0, 0);

        // Start and operand changes during RUN must not disturb the op.
        do_op(8'd200, 8'd77, 1, 0);

        // Back-to-back: start in the DONE cycle, no IDLE between.
        do_op(8'd100, 8'd30, 0, 1);
        do_op(8'd7, 8'd9, 0, 0);

        // Reset in the middle of RUN.
        bus.start = 1'b1;
        bus.A = 8'd50;
        bus.B = 8'd20;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_abort_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_diff", bus.diff, 0);
        chk("abort_borrow", bus.borrow_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            chk("no_done_after_abort", bus.done, 0);
        end

        do_op(8'd255, 8'd255, 0, 0);

        for (int k = 0; k < 16; k++) begin
            do_op(W'($urandom), W'($urandom), 0, (k % 4) == 1);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
